int_arbiter: RTL and testbench
==============================

Name: int_arbiter

Overview:
- Collects external interrupt sources (timer, UART, GPIO) and latches them as pending bits.
- Masks them with a software-writable enable register and selects one by fixed priority.
- Presents the selected source as an encoded interrupt flag to the core-local interrupt controller, and tracks the claim/complete handshake so only one asynchronous interrupt is in service at a time.
- Sits between the peripherals and the core interrupt controller; its registers are mapped on the peripheral bus.

Parameters:
- NUM_SRC, 4, number of interrupt sources; must be 1..31.
- INT_W, 8, width of the encoded interrupt flag output.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- irq_i  input  NUM_SRC  raw source levels, asynchronous to clk; bit k = source ID k+1
- we_i  input  1  bus write strobe
- re_i  input  1  bus read strobe
- addr_i  input  32  bus address; only bits [3:2] decoded
- wdata_i  input  32  bus write data
- rdata_o  output  32  bus read data, registered
- int_ack_i  input  1  one-cycle pulse from the core interrupt controller when it latches an asynchronous cause
- int_flag_o  output  INT_W  encoded request to the core interrupt controller; 0 = none, k+1 = source k
- int_active_o  output  1  high while an interrupt is in service

Behaviour:
- Reset: one clock domain; reset is synchronous and active-low. On a clk edge with rst_n=0, all of the following clear to 0: sync flops, pending, enable, locked ID, state=IDLE, int_flag_o, int_active_o, rdata_o. A reset mid-operation abandons any assert or in-service sequence.
- Input sync: two-flop synchronizer per source, plus a third flop for rising-edge detect.
  - irq_i first sampled high at edge 0 → pending[k] set at edge 2.
  - Level held high does not re-set pending after it is cleared; only a new rising edge does.
- Pending set/clear priority: a rising-edge event and a clear (W1C or claim) on the same bit in the same cycle → set wins.
- Selection: cand = pending & enable; winner = lowest set index. Combinational, used only in IDLE.
- State machine (registered):
  - IDLE: int_flag_o=0.
    - cand≠0 → ASSERT; lock winner ID; int_flag_o=ID from the next cycle.
  - ASSERT: int_flag_o holds the locked ID even if a higher-priority source becomes pending. Exits, in priority order:
    - int_ack_i=1 → IN_SERVICE; clear pending[ID−1]; int_flag_o=0; int_active_o=1.
    - pending[ID−1]=0 or enable[ID−1]=0 (software clear/mask) → IDLE; int_flag_o=0.
    - otherwise stay (e.g. global interrupt enable is off in the core).
  - IN_SERVICE: int_flag_o=0; new events only accumulate in pending.
    - COMPLETE write with wdata_i[4:0]==locked ID → IDLE; int_active_o=0.
    - COMPLETE write with any other ID is ignored.
  - int_ack_i in IDLE or IN_SERVICE is ignored.
- Latency: pending set at edge n → int_flag_o valid after edge n+1, provided state=IDLE.
- Register map (byte offsets; addr_i[3:2]):
  - 0x0 PENDING: read = pending, zero-extended to 32 bits. Write-1-to-clear.
  - 0x4 ENABLE: RW on bits [NUM_SRC-1:0]; upper bits read 0.
  - 0x8 ACTIVE: RO = {int_active_o, 26'b0, locked ID[4:0]}; ID reads 0 in IDLE.
  - 0xC COMPLETE: WO; reads 0.
- Bus timing: re_i at edge n → rdata_o valid after edge n; rdata_o holds until the next read. Writes take effect at the edge where we_i=1. Simultaneous we_i and re_i to the same register → read returns the pre-write value.
- Width rules:
  - int_flag_o = ID zero-extended to INT_W.
  - IDs 1..NUM_SRC never alias 0.

Test Plan:
- ENABLE=0x3, pulse irq_i[1] → PENDING reads 0x2 at edge 2; int_flag_o=2 after edge 3. int_ack_i pulse → int_flag_o=0, ACTIVE=0x80000002, PENDING=0. Write COMPLETE=2 → ACTIVE=0.
- ENABLE=0xF; irq_i[2] event, then irq_i[0] event while in ASSERT → int_flag_o stays 3 until ack. After COMPLETE=3 → int_flag_o=1 next cycle.
- In IN_SERVICE with ID 1: write COMPLETE=2 → still IN_SERVICE. A new irq_i[0] edge → PENDING bit0 set, int_flag_o stays 0 until COMPLETE=1.
- In ASSERT with ID 2: write ENABLE=0x0 → int_flag_o=0 next cycle, PENDING keeps 0x2. Re-enable → int_flag_o=2 again.
- W1C on PENDING bit0 in the same cycle as a new irq_i[0] edge event → PENDING bit0 remains 1. Hold irq_i[0] high continuously after a clear → no new pending.
- Drive rst_n=0 for one edge during IN_SERVICE → all outputs and registers read 0; irq_i held high at release produces no pending until it falls and rises again.

Source files
------------

// File: rtl/int_arbiter.sv
// int_arbiter: fixed-priority interrupt arbiter with pending/enable registers and claim/complete tracking
module int_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int INT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  input  logic               int_ack_i,
  output logic [INT_W-1:0]   int_flag_o,
  output logic               int_active_o
);
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERV} state_t;
  state_t state_q;
  logic [NUM_SRC-1:0] s1_q, s2_q, s3_q, pend_q, pend_d, en_q, en_d;
  logic [NUM_SRC-1:0] rise, cand, w1c, ack_clr, id_oh;
  logic [1:0] warm_q;
  logic [4:0] id_q, win;
  logic [INT_W-1:0] flag_q;
  logic active_q, complete;
  logic [31:0] rdata_q, rdata_d;
  logic unused_ok;
  assign unused_ok = ^{addr_i, wdata_i};
  assign id_oh = NUM_SRC'(1) << (id_q - 5'd1);
  assign complete = we_i && addr_i[3:2] == 2'd3 && wdata_i[4:0] == id_q;
  // Edge detect, pending/enable next state, lowest-index winner and read mux
  always_comb begin
    rise = (warm_q == 2'd3) ? s2_q & ~s3_q : '0;
    cand = pend_q & en_q;
    w1c = (we_i && addr_i[3:2] == 2'd0) ? wdata_i[NUM_SRC-1:0] : '0;
    ack_clr = (state_q == S_ASSERT && int_ack_i) ? id_oh : '0;
    pend_d = (pend_q & ~(w1c | ack_clr)) | rise;
    en_d = (we_i && addr_i[3:2] == 2'd1) ? wdata_i[NUM_SRC-1:0] : en_q;
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (cand[i]) win = 5'(i + 1);
    rdata_d = !re_i ? rdata_q :
              addr_i[3:2] == 2'd0 ? 32'(pend_q) :
              addr_i[3:2] == 2'd1 ? 32'(en_q) :
              addr_i[3:2] == 2'd2 ? {active_q, 26'b0, id_q} : '0;
  end
  // Synchronizers, warm-up gate (edges ignored until the chain holds real post-reset samples) and bus registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      warm_q <= '0;
      pend_q <= '0;
      en_q <= '0;
      rdata_q <= '0;
    end else begin
      s1_q <= irq_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
      warm_q <= (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
      pend_q <= pend_d;
      en_q <= en_d;
      rdata_q <= rdata_d;
    end
  end
  // Claim/complete state machine with registered flag and active outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      id_q <= '0;
      flag_q <= '0;
      active_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (|cand) begin
          state_q <= S_ASSERT;
          id_q <= win;
          flag_q <= INT_W'(win);
        end
        S_ASSERT: if (int_ack_i) begin
          state_q <= S_SERV;
          flag_q <= '0;
          active_q <= 1'b1;
        end else if (~|(pend_q & en_q & id_oh)) begin
          state_q <= S_IDLE;
          id_q <= '0;
          flag_q <= '0;
        end
        S_SERV: if (complete) begin
          state_q <= S_IDLE;
          id_q <= '0;
          active_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign rdata_o = rdata_q;
  assign int_flag_o = flag_q;
  assign int_active_o = active_q;
endmodule

// File: tb/tb_int_arbiter.sv
// tb_int_arbiter: scoreboard bench for int_arbiter
module tb_int_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] irq_i = '0;
  logic we_i = 1'b0, re_i = 1'b0, int_ack_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0, rdata_o;
  logic [7:0] int_flag_o;
  logic int_active_o;
  typedef struct {string name; logic [31:0] v;} exp_t;
  exp_t sb[$];
  logic [31:0] got[$];
  int n_run = 0, n_fail = 0;
  always #5 clk = ~clk;
  int_arbiter #(.NUM_SRC(N), .INT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .we_i(we_i), .re_i(re_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .int_ack_i(int_ack_i),
    .int_flag_o(int_flag_o), .int_active_o(int_active_o)
  );
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic want(input string nm, input logic [31:0] v);
    sb.push_back('{nm, v});
  endtask
  task automatic see(input logic [31:0] v);
    got.push_back(v);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we_i = 1'b1; addr_i = a; wdata_i = d;
    tick();
    we_i = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a);
    re_i = 1'b1; addr_i = a;
    tick();
    re_i = 1'b0;
    got.push_back(rdata_o);
  endtask
  task automatic pulse(input int k);
    irq_i[k] = 1'b1;
    tick();
    irq_i[k] = 1'b0;
  endtask
  task automatic ack();
    int_ack_i = 1'b1;
    tick();
    int_ack_i = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    want("rst_flag", 0); see(int_flag_o);
    want("rst_active", 0); see(int_active_o);
    want("rst_rdata", 0); see(rdata_o);
    rst_n = 1'b1;
    want("rst_pending", 0); rd(0);
    want("rst_enable", 0); rd(4);
    want("rst_active_reg", 0); rd(8);
    tick(3);
    while (sb.size() != 0) begin
      exp_t e; logic [31:0] g;
      e = sb.pop_front();
      if (got.size() != 0) g = got.pop_front(); else g = 'x;
      n_run++;
      if (g !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, g, e.v); end
    end
  endtask
  task automatic test_basic();
    wr(4, 3);
    irq_i[1] = 1'b1;
    tick();
    irq_i[1] = 1'b0;
    tick(2);
    want("lat_flag_early", 0); see(int_flag_o);
    want("basic_pending", 2); rd(0);
    want("basic_flag", 2); see(int_flag_o);
    ack();
    want("ack_flag", 0); see(int_flag_o);
    want("ack_active", 1); see(int_active_o);
    want("ack_active_reg", 32'h8000_0002); rd(8);
    want("ack_pending", 0); rd(0);
    wr(12, 2);
    want("cmpl_active", 0); see(int_active_o);
    want("cmpl_active_reg", 0); rd(8);
    while (sb.size() != 0) begin
      exp_t e; logic [31:0] g;
      e = sb.pop_front();
      if (got.size() != 0) g = got.pop_front(); else g = 'x;
      n_run++;
      if (g !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, g, e.v); end
    end
  endtask
  task automatic test_priority();
    wr(4, 32'hF);
    pulse(2);
    tick(3);
    want("prio_flag3", 3); see(int_flag_o);
    pulse(0);
    tick(3);
    want("prio_hold3", 3); see(int_flag_o);
    want("prio_pending", 5); rd(0);
    ack();
    want("prio_ack_flag", 0); see(int_flag_o);
    want("prio_pending_left", 1); rd(0);
    wr(12, 3);
    want("prio_cmpl_flag", 0); see(int_flag_o);
    tick();
    want("prio_next_flag", 1); see(int_flag_o);
    while (sb.size() != 0) begin
      exp_t e; logic [31:0] g;
      e = sb.pop_front();
      if (got.size() != 0) g = got.pop_front(); else g = 'x;
      n_run++;
      if (g !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, g, e.v); end
    end
  endtask
  task automatic test_wrong_complete();
    ack();
    wr(12, 2);
    want("wrong_cmpl_active", 1); see(int_active_o);
    pulse(0);
    tick(3);
    want("serv_pending", 1); rd(0);
    want("serv_flag", 0); see(int_flag_o);
    wr(12, 1);
    want("right_cmpl_active", 0); see(int_active_o);
    tick();
    want("reassert_flag", 1); see(int_flag_o);
    ack();
    wr(12, 1);
    want("clean_active", 0); see(int_active_o);
    while (sb.size() != 0) begin
      exp_t e; logic [31:0] g;
      e = sb.pop_front();
      if (got.size() != 0) g = got.pop_front(); else g = 'x;
      n_run++;
      if (g !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, g, e.v); end
    end
  endtask
  task automatic test_mask();
    wr(4, 3);
    pulse(1);
    tick(3);
    want("mask_flag_before", 2); see(int_flag_o);
    wr(4, 0);
    tick();
    want("mask_flag_off", 0); see(int_flag_o);
    want("mask_pending", 2); rd(0);
    wr(4, 3);
    want("unmask_flag_early", 0); see(int_flag_o);
    tick();
    want("unmask_flag", 2); see(int_flag_o);
    ack();
    wr(12, 2);
    while (sb.size() != 0) begin
      exp_t e; logic [31:0] g;
      e = sb.pop_front();
      if (got.size() != 0) g = got.pop_front(); else g = 'x;
      n_run++;
      if (g !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, g, e.v); end
    end
  endtask
  task automatic test_set_wins();
    wr(4, 0);
    irq_i[0] = 1'b1;
    tick();
    irq_i[0] = 1'b0;
    tick();
    wr(0, 1);
    want("set_wins", 1); rd(0);
    wr(0, 1);
    want("w1c_clear", 0); rd(0);
    irq_i[0] = 1'b1;
    tick(3);
    want("level_set", 1); rd(0);
    wr(0, 1);
    tick(4);
    want("level_no_reset", 0); rd(0);
    irq_i[0] = 1'b0;
    tick(3);
    while (sb.size() != 0) begin
      exp_t e; logic [31:0] g;
      e = sb.pop_front();
      if (got.size() != 0) g = got.pop_front(); else g = 'x;
      n_run++;
      if (g !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, g, e.v); end
    end
  endtask
  task automatic test_reset_mid();
    wr(4, 1);
    pulse(0);
    tick(3);
    ack();
    want("mid_active", 1); see(int_active_o);
    irq_i[0] = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    want("mid_rst_flag", 0); see(int_flag_o);
    want("mid_rst_active", 0); see(int_active_o);
    want("mid_rst_rdata", 0); see(rdata_o);
    want("mid_rst_pending", 0); rd(0);
    want("mid_rst_enable", 0); rd(4);
    want("mid_rst_active_reg", 0); rd(8);
    tick(3);
    want("held_high_no_pend", 0); rd(0);
    irq_i[0] = 1'b0;
    tick(3);
    irq_i[0] = 1'b1;
    tick(3);
    want("new_edge_pend", 1); rd(0);
    irq_i[0] = 1'b0;
    while (sb.size() != 0) begin
      exp_t e; logic [31:0] g;
      e = sb.pop_front();
      if (got.size() != 0) g = got.pop_front(); else g = 'x;
      n_run++;
      if (g !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, g, e.v); end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_wrong_complete();
    test_mask();
    test_set_wins();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
